led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 144 ++++++++++++++
 tb/tb_led_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate-left/right, ping-pong and bar fill/drain patterns
// advanced one step per accepted strobe, with mode-change reload and registered outputs.
module led_sequencer #(
    parameter int unsigned NB_LED = 4
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [1:0]        i_mode,
    input  logic              i_hold,
    output logic [NB_LED-1:0] o_led,
    output logic              o_dir,
    output logic              o_wrap
);

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ROL  = 2'd0,
        MODE_ROR  = 2'd1,
        MODE_PING = 2'd2,
        MODE_BAR  = 2'd3
    } mode_e;

    typedef enum logic {
        GO_LEFT  = 1'b0,
        GO_RIGHT = 1'b1
    } state_e;

    localparam logic [NB_LED-1:0] LED_LSB  = NB_LED'(1);
    localparam logic [NB_LED-1:0] LED_ONES = {NB_LED{1'b1}};

    state_e              state_q, state_d;
    mode_e               mode_q;
    logic [NB_LED-1:0]   led_q, led_d;
    logic                dir_q, dir_d;
    logic                wrap_q, wrap_d;

    logic                mode_chg_c;
    logic                step_c;
    logic [NB_LED-1:0]   rol_c, ror_c, shl_c, shr_c, fill_c;

    assign mode_chg_c = (mode_e'(i_mode) != mode_q);
    assign step_c     = i_valid & ~i_hold & ~mode_chg_c;

    // Candidate next patterns; "left" is toward the MSB.
    assign rol_c  = {led_q[NB_LED-2:0], led_q[NB_LED-1]};
    assign ror_c  = {led_q[0], led_q[NB_LED-1:1]};
    assign shl_c  = {led_q[NB_LED-2:0], 1'b0};
    assign shr_c  = {1'b0, led_q[NB_LED-1:1]};
    assign fill_c = {led_q[NB_LED-2:0], 1'b1};

    // FSM state register
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= GO_LEFT;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode is registered every cycle, including under reset, so release never triggers a reload.
    always_ff @(posedge clock) begin
        mode_q <= mode_e'(i_mode);
    end

    // Registered outputs
    always_ff @(posedge clock) begin
        if (i_reset) begin
            led_q  <= LED_LSB;
            dir_q  <= 1'b1;
            wrap_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;

        if (mode_chg_c) begin
            led_d   = LED_LSB;
            state_d = GO_LEFT;
            dir_d   = (mode_e'(i_mode) != MODE_ROR);
        end else if (step_c) begin
            case (mode_q)
                MODE_ROL: begin
                    led_d  = rol_c;
                    dir_d  = 1'b1;
                    wrap_d = (rol_c == LED_LSB);
                end
                MODE_ROR: begin
                    led_d  = ror_c;
                    dir_d  = 1'b0;
                    wrap_d = (ror_c == LED_LSB);
                end
                MODE_PING: begin
                    if (state_q == GO_LEFT) begin
                        led_d = shl_c;
                        if (shl_c[NB_LED-1]) begin
                            state_d = GO_RIGHT;
                        end
                    end else begin
                        led_d = shr_c;
                        if (shr_c == LED_LSB) begin
                            state_d = GO_LEFT;
                            wrap_d  = 1'b1;
                        end
                    end
                    dir_d = (state_d == GO_LEFT);
                end
                MODE_BAR: begin
                    if (state_q == GO_LEFT) begin
                        led_d = fill_c;
                        if (fill_c == LED_ONES) begin
                            state_d = GO_RIGHT;
                        end
                    end else begin
                        led_d = shr_c;
                        if (shr_c == LED_LSB) begin
                            state_d = GO_LEFT;
                            wrap_d  = 1'b1;
                        end
                    end
                    dir_d = (state_d == GO_LEFT);
                end
                default: begin
                    led_d = led_q;
                end
            endcase
        end
    end

    assign o_led  = led_q;
    assign o_dir  = dir_q;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (NB_LED=4): each driven cycle pushes its expected
// outputs to a scoreboard queue, popped and checked one edge later.
module tb_led_sequencer;

    localparam int unsigned NB = 4;

    typedef struct packed {
        logic [NB-1:0] led;
        logic          dir;
        logic          wrap;
    } exp_t;

    logic          clock = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_valid = 1'b0;
    logic [1:0]    i_mode = 2'd0;
    logic          i_hold = 1'b0;
    logic [NB-1:0] o_led;
    logic          o_dir;
    logic          o_wrap;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    led_sequencer #(.NB_LED(NB)) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .i_mode (i_mode),
        .i_hold (i_hold),
        .o_led  (o_led),
        .o_dir  (o_dir),
        .o_wrap (o_wrap)
    );

    always #5 clock = ~clock;

    // Drive one cycle, queue the expected outputs, then compare after the edge.
    task automatic cyc(input logic rst, input logic valid, input logic hold,
                       input logic [1:0] mode, input logic [NB-1:0] e_led,
                       input logic e_dir, input logic e_wrap, input string tag);
        exp_t e;
        @(negedge clock);
        i_reset = rst;
        i_valid = valid;
        i_hold  = hold;
        i_mode  = mode;
        exp_q.push_back('{led: e_led, dir: e_dir, wrap: e_wrap});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        total++;
        assert (o_led === e.led)
            else begin bad++; $error("FAIL %s led got=%b exp=%b", tag, o_led, e.led); end
        total++;
        assert (o_dir === e.dir)
            else begin bad++; $error("FAIL %s dir got=%b exp=%b", tag, o_dir, e.dir); end
        total++;
        assert (o_wrap === e.wrap)
            else begin bad++; $error("FAIL %s wrap got=%b exp=%b", tag, o_wrap, e.wrap); end
    endtask

    // One strobe followed by two idle cycles, during which outputs must hold with wrap low.
    task automatic spaced(input logic [1:0] mode, input logic [NB-1:0] e_led,
                          input logic e_dir, input logic e_wrap, input string tag);
        cyc(1'b0, 1'b1, 1'b0, mode, e_led, e_dir, e_wrap, tag);
        cyc(1'b0, 1'b0, 1'b0, mode, e_led, e_dir, 1'b0, {tag, "_idle1"});
        cyc(1'b0, 1'b0, 1'b0, mode, e_led, e_dir, 1'b0, {tag, "_idle2"});
    endtask

    initial begin
        // Rotate-left, spaced pulses
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "rst_m0");
        spaced(2'd0, 4'b0010, 1'b1, 1'b0, "rol1");
        spaced(2'd0, 4'b0100, 1'b1, 1'b0, "rol2");
        spaced(2'd0, 4'b1000, 1'b1, 1'b0, "rol3");
        spaced(2'd0, 4'b0001, 1'b1, 1'b1, "rol4");
        spaced(2'd0, 4'b0010, 1'b1, 1'b0, "rol5");
        spaced(2'd0, 4'b0100, 1'b1, 1'b0, "rol6");

        // Ping-pong from reset
        cyc(1'b1, 1'b0, 1'b0, 2'd2, 4'b0001, 1'b1, 1'b0, "rst_m2");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0010, 1'b1, 1'b0, "pp1");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "pp2");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b0, 1'b0, "pp3");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 1'b0, "pp4");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0010, 1'b0, 1'b0, "pp5");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0001, 1'b1, 1'b1, "pp6");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0010, 1'b1, 1'b0, "pp7");

        // Bar fill/drain with valid held high
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 4'b0001, 1'b1, 1'b0, "rst_m3");
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'b0011, 1'b1, 1'b0, "bar1");
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'b0111, 1'b1, 1'b0, "bar2");
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'b1111, 1'b0, 1'b0, "bar3");
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'b0111, 1'b0, 1'b0, "bar4");
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'b0011, 1'b0, 1'b0, "bar5");
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'b0001, 1'b1, 1'b1, "bar6");
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'b0011, 1'b1, 1'b0, "bar7");
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 4'b0111, 1'b1, 1'b0, "bar8");

        // Mode change coinciding with a strobe drops the step
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b0, "rst_m0b");
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 1'b0, "mc_rol1");
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 1'b0, "mc_rol2");
        cyc(1'b0, 1'b1, 1'b0, 2'd1, 4'b0001, 1'b0, 1'b0, "mc_reload");
        cyc(1'b0, 1'b1, 1'b0, 2'd1, 4'b1000, 1'b0, 1'b0, "mc_ror1");

        // Hold freezes the pattern but not the mode-change reload
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 2'd1, 4'b1000, 1'b0, 1'b0, "hold");
        end
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "hold_reload");
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b0, "hold_after");

        // Reset aborts ping-pong mid-sequence and beats a coincident strobe
        cyc(1'b1, 1'b0, 1'b0, 2'd2, 4'b0001, 1'b1, 1'b0, "rst_m2b");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0010, 1'b1, 1'b0, "ab1");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, "ab2");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b0, 1'b0, "ab3");
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 4'b0001, 1'b1, 1'b0, "ab_rst");
        cyc(1'b0, 1'b1, 1'b0, 2'd2, 4'b0010, 1'b1, 1'b0, "ab_post");

        // Reset in rotate-right: dir forced to 1, no reload after release
        cyc(1'b1, 1'b0, 1'b0, 2'd1, 4'b0001, 1'b1, 1'b0, "rst_m1");
        cyc(1'b0, 1'b1, 1'b0, 2'd1, 4'b1000, 1'b0, 1'b0, "ror1");
        cyc(1'b0, 1'b1, 1'b0, 2'd1, 4'b0100, 1'b0, 1'b0, "ror2");
        cyc(1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b0, 1'b0, "ror3");
        cyc(1'b0, 1'b1, 1'b0, 2'd1, 4'b0001, 1'b0, 1'b1, "ror4");
        cyc(1'b0, 1'b0, 1'b0, 2'd1, 4'b0001, 1'b0, 1'b0, "ror_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
